// File: rtl/decoder_residual_stage.sv
// Decoder sublayer wrapper: forwards token beats to an external sublayer, keeps each
// beat in a residual FIFO and emits sat(x + rsp) (or rsp alone) through an output register.
module decoder_residual_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int BEATS_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_start,
  input  logic [BEATS_W-1:0]          cfg_beats,
  input  logic [BEATS_W-1:0]          cfg_tokens,
  input  logic                        cfg_residual_en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        sub_req_valid,
  input  logic                        sub_req_ready,
  output logic [LANES*DATA_WIDTH-1:0] sub_req_data,
  input  logic                        sub_rsp_valid,
  output logic                        sub_rsp_ready,
  input  logic [LANES*DATA_WIDTH-1:0] sub_rsp_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic [31:0]                 perf_cycle_count,
  output logic [15:0]                 perf_sat_count
);

  localparam int BW    = LANES * DATA_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [BEATS_W-1:0] beats_q, tokens_q;
  logic               res_en_q;
  logic [BEATS_W-1:0] beat_cnt_q, tok_cnt_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               out_valid_q;
  logic [BW-1:0]      out_data_q;
  logic               out_last_q;
  logic               done_q, done_d;
  logic [31:0]        perf_cyc_q;
  logic [15:0]        perf_sat_q;

  // Each entry holds the input beat plus its last-of-token flag in the MSB.
  logic [BW:0]        fifo_mem [FIFO_DEPTH];
  logic [BW:0]        fifo_head;

  logic start_ok, running, fifo_full, fifo_empty, push, pop;
  logic beat_last, tok_last;

  assign start_ok   = cfg_start && (state_q == ST_IDLE);
  assign running    = (state_q == ST_RUN);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = fifo_mem[rd_ptr_q];

  assign sub_req_valid = in_valid && running && !fifo_full;
  assign sub_req_data  = in_data;
  assign in_ready      = running && !fifo_full && sub_req_ready;
  assign push          = in_valid && in_ready;
  assign sub_rsp_ready = !fifo_empty && (!out_valid_q || out_ready);
  assign pop           = sub_rsp_valid && sub_rsp_ready;

  assign beat_last = (beat_cnt_q == beats_q - BEATS_W'(1));
  assign tok_last  = (tok_cnt_q == tokens_q - BEATS_W'(1));

  // Lane-wise residual add with signed clamp; overflow shows as differing top two sum bits.
  logic [BW-1:0]         sum_data, rsp_result;
  logic                  any_sat, beat_sat;
  logic [DATA_WIDTH-1:0] lane_x, lane_r;
  logic [DATA_WIDTH:0]   lane_sum;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum_data = '0;
    any_sat  = 1'b0;
    lane_x   = '0;
    lane_r   = '0;
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_x   = fifo_head[i*DATA_WIDTH +: DATA_WIDTH];
      lane_r   = sub_rsp_data[i*DATA_WIDTH +: DATA_WIDTH];
      lane_sum = {lane_x[DATA_WIDTH-1], lane_x} + {lane_r[DATA_WIDTH-1], lane_r};
      if (lane_sum[DATA_WIDTH] != lane_sum[DATA_WIDTH-1]) begin
        any_sat = 1'b1;
        sum_data[i*DATA_WIDTH +: DATA_WIDTH] =
          {lane_sum[DATA_WIDTH], {(DATA_WIDTH-1){~lane_sum[DATA_WIDTH]}}};
      end else begin
        sum_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_sum[DATA_WIDTH-1:0];
      end
    end
  end

  assign rsp_result = res_en_q ? sum_data : sub_rsp_data;
  assign beat_sat   = res_en_q && any_sat;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE:  if (cfg_start) state_d = ST_RUN;
      ST_RUN:   if (push && beat_last && tok_last) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && (!out_valid_q || out_ready)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beats_q    <= BEATS_W'(1);
      tokens_q   <= BEATS_W'(1);
      res_en_q   <= 1'b0;
      beat_cnt_q <= '0;
      tok_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      perf_cyc_q <= '0;
      perf_sat_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      count_q <= count_d;
      if (start_ok) begin
        beats_q    <= (cfg_beats == '0) ? BEATS_W'(1) : cfg_beats;
        tokens_q   <= (cfg_tokens == '0) ? BEATS_W'(1) : cfg_tokens;
        res_en_q   <= cfg_residual_en;
        beat_cnt_q <= '0;
        tok_cnt_q  <= '0;
        perf_cyc_q <= '0;
        perf_sat_q <= '0;
      end else begin
        if (state_q != ST_IDLE) perf_cyc_q <= perf_cyc_q + 32'd1;
        if (pop && beat_sat && (perf_sat_q != 16'hFFFF)) perf_sat_q <= perf_sat_q + 16'd1;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (beat_last) begin
          beat_cnt_q <= '0;
          tok_cnt_q  <= tok_last ? '0 : tok_cnt_q + BEATS_W'(1);
        end else begin
          beat_cnt_q <= beat_cnt_q + BEATS_W'(1);
        end
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: the FIFO storage is not reset; occupancy is tracked by count_q, so stale data is never read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {beat_last, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_data_q  <= rsp_result;
      out_last_q  <= fifo_head[BW];
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_last         = out_last_q;
  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;
  assign perf_cycle_count = perf_cyc_q;
  assign perf_sat_count   = perf_sat_q;

`ifndef SYNTHESIS
  // A response with nothing buffered means the sublayer broke request ordering.
  rsp_without_entry: assert property (@(posedge clk) disable iff (!rst_n)
    !(sub_rsp_valid && fifo_empty))
    else $error("sub_rsp_valid asserted while residual FIFO is empty");
`endif

endmodule

// File: tb/tb_decoder_residual_stage.sv
// Scoreboard bench for decoder_residual_stage: random beats and responses are checked
// against a lane-wise integer model of the residual add with saturation.
module tb_decoder_residual_stage;

  localparam int DW = 16;
  localparam int L  = 4;
  localparam int W  = DW * L;

  typedef struct { logic [W-1:0] x; logic [W-1:0] r; } beat_t;
  typedef struct { logic [W-1:0] d; logic last; } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_start = 1'b0;
  logic [7:0]   cfg_beats = '0;
  logic [7:0]   cfg_tokens = '0;
  logic         cfg_residual_en = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         sub_req_valid;
  logic         sub_req_ready = 1'b0;
  logic [W-1:0] sub_req_data;
  logic         sub_rsp_valid = 1'b0;
  logic         sub_rsp_ready;
  logic [W-1:0] sub_rsp_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;
  logic [31:0]  perf_cycle_count;
  logic [15:0]  perf_sat_count;

  decoder_residual_stage #(.DATA_WIDTH(DW), .LANES(L), .FIFO_DEPTH(16), .BEATS_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_beats(cfg_beats),
    .cfg_tokens(cfg_tokens), .cfg_residual_en(cfg_residual_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sub_req_valid(sub_req_valid), .sub_req_ready(sub_req_ready), .sub_req_data(sub_req_data),
    .sub_rsp_valid(sub_rsp_valid), .sub_rsp_ready(sub_rsp_ready), .sub_rsp_data(sub_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .perf_cycle_count(perf_cycle_count),
    .perf_sat_count(perf_sat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t        in_q[$];
  logic [W-1:0] sub_q[$];
  exp_t         exp_q[$];

  int n_checks = 0, n_pass = 0;
  bit rsp_en = 1'b0;
  int rsp_pct = 100, in_pct = 100, req_pct = 100, out_mode = 1;
  int m_beats = 1, m_tokens = 1, acc_cnt = 0, m_sat = 0, out_cnt = 0;
  int last_xfer_cyc = 0, start_cyc = 0;
  bit m_res_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] pack(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Reference: plain integer sum per lane, clamped to the 16-bit signed range.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] r, input bit res_en,
                                output logic [W-1:0] y, output bit sat);
    sat = 1'b0;
    y   = r;
    if (res_en) begin
      for (int i = 0; i < L; i++) begin
        int s;
        s = int'($signed(x[i*DW +: DW])) + int'($signed(r[i*DW +: DW]));
        if (s > 32767) begin s = 32767; sat = 1'b1; end
        else if (s < -32768) begin s = -32768; sat = 1'b1; end
        y[i*DW +: DW] = 16'(s);
      end
    end
  endfunction

  // Drivers: input stream, sublayer (responds in request order), output sink.
  always @(negedge clk) begin
    if (in_q.size() > 0 && (in_valid || $urandom_range(99) < in_pct)) begin
      in_valid = 1'b1;
      in_data  = in_q[0].x;
    end else begin
      in_valid = 1'b0;
      in_data  = '0;
    end
    sub_req_ready = ($urandom_range(99) < req_pct);
    if (rsp_en && sub_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
      sub_rsp_valid = 1'b1;
      sub_rsp_data  = sub_q[0];
    end else begin
      sub_rsp_valid = 1'b0;
      sub_rsp_data  = '0;
    end
    case (out_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(99) < 60);
    endcase
  end

  // Stimulus side: on each accepted beat, queue its response and the expected output.
  beat_t        smp_b;
  logic [W-1:0] smp_y;
  bit           smp_sat;
  always @(negedge clk) begin
    #4;
    if (rst_n) begin
      if (in_valid && in_ready && in_q.size() > 0) begin
        smp_b = in_q.pop_front();
        check("req_data_fwd", sub_req_data, smp_b.x);
        sub_q.push_back(smp_b.r);
        model(smp_b.x, smp_b.r, m_res_en, smp_y, smp_sat);
        exp_q.push_back('{d: smp_y, last: ((acc_cnt % m_beats) == m_beats - 1)});
        if (smp_sat) m_sat++;
        acc_cnt++;
      end
      if (sub_rsp_valid && sub_rsp_ready && sub_q.size() > 0) void'(sub_q.pop_front());
    end
  end

  // Monitor: every output transfer is compared with the scoreboard head.
  exp_t mon_e;
  always @(negedge clk) begin
    #4;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1'b1, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", out_data, mon_e.d);
        check("out_last", out_last, mon_e.last);
      end
      out_cnt++;
      last_xfer_cyc = cyc;
    end
  end

  task automatic start_run(input int beats, input int tokens, input bit res_en);
    @(negedge clk); #1;
    m_beats  = (beats == 0) ? 1 : beats;
    m_tokens = (tokens == 0) ? 1 : tokens;
    m_res_en = res_en;
    acc_cnt  = 0;
    m_sat    = 0;
    cfg_beats       = 8'(beats);
    cfg_tokens      = 8'(tokens);
    cfg_residual_en = res_en;
    cfg_start       = 1'b1;
    start_cyc       = cyc + 1;
    @(negedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) in_q.push_back('{x: {$urandom, $urandom}, r: {$urandom, $urandom}});
  endtask

  task automatic wait_acc(input int n);
    for (int k = 0; k < 1000 && acc_cnt < n; k++) begin @(negedge clk); #4; end
    check("accepted_count", acc_cnt >= n, 1'b1);
  endtask

  task automatic finish_run(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk); #4;
      if (done) begin seen = 1'b1; break; end
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      check({tag, "_done_latency"}, cyc, last_xfer_cyc + 1);
      check({tag, "_perf_cycles"}, perf_cycle_count, cyc - start_cyc);
      check({tag, "_perf_sat"}, perf_sat_count, m_sat);
      check({tag, "_busy_low"}, busy, 1'b0);
      check({tag, "_all_out"}, exp_q.size(), 0);
      @(negedge clk); #4;
      check({tag, "_done_pulse"}, done, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #4;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_busy_done", {busy, done, out_last}, 3'b000);
    check("rst_perf", {perf_cycle_count, perf_sat_count}, '0);
    check("rst_ready", {in_ready, sub_rsp_ready}, 2'b00);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Basic two-beat token, response equals input.
    rsp_en = 1'b1;
    start_run(2, 1, 1'b1);
    in_q.push_back('{x: pack(1, 2, 3, 4), r: pack(1, 2, 3, 4)});
    in_q.push_back('{x: pack(-5, 0, 7, 8), r: pack(-5, 0, 7, 8)});
    finish_run("basic");

    // Positive and negative clamp on lane 0.
    start_run(2, 1, 1'b1);
    in_q.push_back('{x: pack(32767, 10, -10, 0), r: pack(1, 5, 5, 0)});
    in_q.push_back('{x: pack(-32768, 1, 2, 3), r: pack(-1, 1, 1, 1)});
    finish_run("sat");
    check("sat_count_two", perf_sat_count, 16'd2);

    // Fill the FIFO with the sublayer silent, then stall the output.
    rsp_en = 1'b0;
    start_run(20, 1, 1'b1);
    push_random(20);
    wait_acc(16);
    repeat (3) begin
      @(negedge clk); #4;
      check("full_in_ready", in_ready, 1'b0);
      check("full_no_accept", acc_cnt, 16);
    end
    out_mode = 0;
    rsp_en   = 1'b1;
    for (int k = 0; k < 50 && !out_valid; k++) begin @(negedge clk); #4; end
    check("stall_out_valid", out_valid, 1'b1);
    repeat (5) begin
      @(negedge clk); #4;
      check("stall_out_data", out_data, (exp_q.size() > 0) ? exp_q[0].d : '0);
      check("stall_no_pop", sub_rsp_ready, 1'b0);
    end
    out_mode = 2;
    finish_run("bp");

    // Pass-through mode, three tokens of four beats, with a start pulse mid-run.
    rsp_pct = 70; in_pct = 70; req_pct = 80; out_mode = 2;
    start_run(4, 3, 1'b0);
    push_random(12);
    wait_acc(3);
    @(negedge clk); #1;
    cfg_beats = 8'd1; cfg_tokens = 8'd1; cfg_residual_en = 1'b1; cfg_start = 1'b1;
    @(negedge clk); #1;
    cfg_start = 1'b0;
    #3;
    check("restart_ignored_busy", busy, 1'b1);
    finish_run("bypass");

    // Reset in the middle of a run with five beats buffered.
    rsp_en = 1'b0; in_pct = 100; req_pct = 100;
    start_run(10, 1, 1'b1);
    push_random(5);
    wait_acc(5);
    @(negedge clk); #1;
    rst_n = 1'b0;
    in_q.delete(); sub_q.delete(); exp_q.delete();
    #1;
    check("mid_rst_out", {out_valid, out_last, out_data}, '0);
    check("mid_rst_status", {busy, done, in_ready, sub_rsp_ready, sub_req_valid}, 5'b0);
    check("mid_rst_perf", {perf_cycle_count, perf_sat_count}, '0);
    @(negedge clk); #1;
    rst_n  = 1'b1;
    rsp_en = 1'b1;
    start_run(3, 2, 1'b1);
    push_random(6);
    finish_run("after_rst");

    // Zero beats per token means one; run near full with random stalls everywhere.
    rsp_en = 1'b0; in_pct = 100; req_pct = 100; out_mode = 2;
    start_run(0, 40, 1'b1);
    push_random(40);
    wait_acc(16);
    rsp_en  = 1'b1;
    rsp_pct = 60;
    finish_run("full_stream");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
